// File: rtl/a5_1.sv
// Bit-serial A5/1 keystream core: key load, optional warm-up, keystream with 64-bit history.
// Optional 100-cycle mixing phase is enabled by defining A51_WARMUP_EN.
module a5_1 (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] key,
  input  logic [63:0] plaintext,
  output logic        z,
  output logic [63:0] ciphertext,
  output logic        ks_valid
);

  typedef enum logic [1:0] {
    ST_LOAD      = 2'd0,
    ST_WARMUP    = 2'd1,
    ST_KEYSTREAM = 2'd2
  } state_t;

  localparam logic [6:0] LOAD_LAST   = 7'd63;
  localparam logic [6:0] WARMUP_LAST = 7'd99;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [18:0] r1_q, r1_d;
  logic [21:0] r2_q, r2_d;
  logic [22:0] r3_q, r3_d;
  logic [63:0] ks_q, ks_d;

  logic fb1, fb2, fb3;
  logic maj, z_raw, in_load, in_ks, inj;
  logic en1, en2, en3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      ks_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      ks_q    <= ks_d;
    end
  end

  // Datapath: all registers step during load; afterwards only those agreeing with the majority.
  always_comb begin
    fb1     = r1_q[13] ^ r1_q[16] ^ r1_q[17] ^ r1_q[18];
    fb2     = r2_q[20] ^ r2_q[21];
    fb3     = r3_q[7] ^ r3_q[20] ^ r3_q[21] ^ r3_q[22];
    maj     = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
    z_raw   = r1_q[18] ^ r2_q[21] ^ r3_q[22];
    in_load = (state_q == ST_LOAD);
    in_ks   = (state_q == ST_KEYSTREAM);
    inj     = in_load & key[cnt_q[5:0]];
    en1     = in_load | (r1_q[8]  == maj);
    en2     = in_load | (r2_q[10] == maj);
    en3     = in_load | (r3_q[10] == maj);
    r1_d    = en1 ? {r1_q[17:0], fb1 ^ inj} : r1_q;
    r2_d    = en2 ? {r2_q[20:0], fb2 ^ inj} : r2_q;
    r3_d    = en3 ? {r3_q[21:0], fb3 ^ inj} : r3_q;
    ks_d    = in_ks ? {ks_q[62:0], z_raw} : ks_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d = '0;
`ifdef A51_WARMUP_EN
          state_d = ST_WARMUP;
`else
          state_d = ST_KEYSTREAM;
`endif
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_WARMUP: begin
        if (cnt_q == WARMUP_LAST) begin
          cnt_d   = '0;
          state_d = ST_KEYSTREAM;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_KEYSTREAM: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 7'd1;
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ks_valid   = (state_q == ST_KEYSTREAM);
    z          = ks_valid & z_raw;
    ciphertext = plaintext ^ ks_q;
  end

endmodule

// File: tb/tb_a5_1.sv
// Randomized self-checking bench for a5_1 against a cycle-count-driven A5/1 reference model.
module tb_a5_1;

`ifdef A51_WARMUP_EN
  localparam int LAT = 164;
`else
  localparam int LAT = 64;
`endif
  localparam logic [22:0] T1 = (23'd1 << 13) | (23'd1 << 16) | (23'd1 << 17) | (23'd1 << 18);
  localparam logic [22:0] T2 = (23'd1 << 20) | (23'd1 << 21);
  localparam logic [22:0] T3 = (23'd1 << 7) | (23'd1 << 20) | (23'd1 << 21) | (23'd1 << 22);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] key = '0;
  logic [63:0] plaintext = '0;
  logic        z;
  logic [63:0] ciphertext;
  logic        ks_valid;

  int checks = 0;
  int failures = 0;

  logic [22:0] m_r1, m_r2, m_r3;
  logic [63:0] m_ks, m_key;
  int          m_edges;
  int          first_valid;
  int          pt_mode;
  logic [63:0] zhist;

  a5_1 dut (
    .clk(clk), .reset(reset), .key(key), .plaintext(plaintext),
    .z(z), .ciphertext(ciphertext), .ks_valid(ks_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] lfsr(input logic [22:0] r, input int n,
                                       input logic [22:0] taps, input logic inj);
    logic        fb;
    logic [22:0] mask;
    fb   = (^(r & taps)) ^ inj;
    mask = (23'd1 << n) - 23'd1;
    return ((r << 1) | {22'd0, fb}) & mask;
  endfunction

  function automatic logic m_zraw();
    return m_r1[18] ^ m_r2[21] ^ m_r3[22];
  endfunction

  task automatic model_reset(input logic [63:0] k);
    m_r1 = '0; m_r2 = '0; m_r3 = '0; m_ks = '0;
    m_key = k; m_edges = 0; first_valid = -1; zhist = '0;
  endtask

  task automatic model_edge();
    logic inj, mj, a, b, c;
    if (m_edges < 64) begin
      inj  = m_key[m_edges];
      m_r1 = lfsr(m_r1, 19, T1, inj);
      m_r2 = lfsr(m_r2, 22, T2, inj);
      m_r3 = lfsr(m_r3, 23, T3, inj);
    end else begin
      if (m_edges >= LAT) m_ks = {m_ks[62:0], m_zraw()};
      a  = m_r1[8]; b = m_r2[10]; c = m_r3[10];
      mj = (int'(a) + int'(b) + int'(c)) >= 2;
      if (a == mj) m_r1 = lfsr(m_r1, 19, T1, 1'b0);
      if (b == mj) m_r2 = lfsr(m_r2, 22, T2, 1'b0);
      if (c == mj) m_r3 = lfsr(m_r3, 23, T3, 1'b0);
    end
    m_edges++;
  endtask

  // Called at a falling edge: drive plaintext, compare, advance model across the next rising edge.
  task automatic cycle();
    logic in_ks;
    if (pt_mode == 1) plaintext = {plaintext[62:0], plaintext[63]};
    else plaintext = {$urandom, $urandom};
    #1;
    in_ks = (m_edges >= LAT);
    if (ks_valid === 1'b1 && first_valid < 0) first_valid = m_edges;
    if (in_ks) zhist = {zhist[62:0], z};
    check("z", {63'd0, z}, {63'd0, in_ks & m_zraw()});
    check("ks_valid", {63'd0, ks_valid}, {63'd0, in_ks});
    check("ciphertext", ciphertext, plaintext ^ m_ks);
    check("r1", {45'd0, dut.r1_q}, {41'd0, m_r1});
    check("r2", {42'd0, dut.r2_q}, {41'd0, m_r2});
    check("r3", {41'd0, dut.r3_q}, {41'd0, m_r3});
    check("ks", dut.ks_q, m_ks);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_to(input int n);
    while (m_edges < n) cycle();
  endtask

  task automatic start(input logic [63:0] k);
    reset = 1'b1;
    key   = k;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset(k);
  endtask

  initial begin
    logic [63:0] k, z_first;

    // Reset values
    plaintext = 64'hFEDCBA9876543210;
    repeat (2) @(negedge clk);
    #1;
    check("rst_z", {63'd0, z}, 64'd0);
    check("rst_ks_valid", {63'd0, ks_valid}, 64'd0);
    check("rst_ciphertext", ciphertext, 64'hFEDCBA9876543210);

    // Zero key: all-zero state is a fixed point
    pt_mode = 0;
    start(64'd0);
    run_to(LAT + 40);

    // Known key: latency and 128 keystream cycles with rotating plaintext
    start(64'h123456789ABCDEF0);
    pt_mode = 1;
    plaintext = {$urandom, $urandom};
    run_to(LAT + 128);
    check("latency", 64'(first_valid), 64'(LAT));

    // Single-bit key: injection lands in bit 0 of every register after load cycle 0
    pt_mode = 0;
    start(64'h1);
    cycle();
    check("load0_r1", {45'd0, dut.r1_q}, 64'd1);
    check("load0_r2", {42'd0, dut.r2_q}, 64'd1);
    check("load0_r3", {41'd0, dut.r3_q}, 64'd1);
    run_to(LAT + 30);

    // Random key, key change after load, reset mid-keystream, bit-identical rerun
    k = {$urandom, $urandom};
    start(k);
    run_to(64);
    key = {$urandom, $urandom};
    run_to(LAT + 20);
    z_first = zhist;
    #2 reset = 1'b1;
    plaintext = {$urandom, $urandom};
    #1;
    check("midrst_ks", dut.ks_q, 64'd0);
    check("midrst_ciphertext", ciphertext, plaintext);
    check("midrst_z", {63'd0, z}, 64'd0);
    check("midrst_ks_valid", {63'd0, ks_valid}, 64'd0);
    key = k;
    @(negedge clk);
    reset = 1'b0;
    model_reset(k);
    run_to(LAT + 20);
    check("rerun_z", zhist, z_first);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/a5_1.md
# a5_1

Bit-serial A5/1 stream-cipher core. It loads a 64-bit session key into the three standard majority-clocked LFSRs. It then produces one keystream bit per clock and keeps the last 64 keystream bits in a shift register. That register is XORed combinationally with a 64-bit plaintext word to form the ciphertext. The core sits between the key-management logic and the data path as a self-contained encryption leaf.

## Interface
- No parameters.
- clk, input, 1: sole clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high; clears all state.
- key, input, 64: session key; bit i is consumed on load cycle i; must be held stable during LOAD.
- plaintext, input, 64: data word; may change any time.
- z, output, 1: current keystream bit; 0 outside KEYSTREAM.
- ciphertext, output, 64: plaintext ^ ks (combinational).
- ks_valid, output, 1: high while in KEYSTREAM.

## Operation
- Registers:
  - R1[18:0]: feedback R1[13]^R1[16]^R1[17]^R1[18]; clocking bit R1[8].
  - R2[21:0]: feedback R2[20]^R2[21]; clocking bit R2[10].
  - R3[22:0]: feedback R3[7]^R3[20]^R3[21]^R3[22]; clocking bit R3[10].
- Step: R <= {R[n-2:0], fb}.
- Majority: maj = majority(R1[8], R2[10], R3[10]). A register steps only if its clocking bit equals maj, so 2 or 3 registers step per cycle.
- Output function: z_raw = R1[18]^R2[21]^R3[22]. z = z_raw in KEYSTREAM, else 0.
- States:
  - LOAD: 64 cycles, counter 0..63. All three registers step unconditionally with fb ^ key[cnt]. After cnt=63 go to WARMUP if A51_WARMUP_EN is defined, else to KEYSTREAM.
  - WARMUP: 100 majority-clocked cycles, output discarded, ks untouched; then go to KEYSTREAM.
  - KEYSTREAM: every cycle ks <= {ks[62:0], z_raw}, then majority-step using the pre-edge register values. Stays here until reset.
- There is no frame-number injection.
- Counter: 7 bits; saturates and is unused in KEYSTREAM.

## Timing
- Reset (async assert, released synchronously to clk by the system):
  - R1/R2/R3 = 0, ks = 0, cnt = 0, state = LOAD.
  - z = 0, ks_valid = 0, ciphertext = plaintext.
- LOAD begins on the first rising edge after reset deasserts.
- ks_valid rises after 64 edges with the macro undefined, or 164 edges with it defined.
- The first z is valid in the same cycle ks_valid rises. The first keystream bit enters ks[0] on the next edge.
- A full 64-bit ks window requires 64 KEYSTREAM edges.
- ciphertext is purely combinational: zero latency from plaintext or ks.
- Reset mid-operation (any state): immediate clear and restart from LOAD cycle 0.
- All-zero register state is a fixed point: z stays 0 forever.
- Changing key outside LOAD has no effect.

## Configuration
- A51_WARMUP_EN defined: the standard 100-cycle discarded mixing phase runs between LOAD and KEYSTREAM.
- A51_WARMUP_EN undefined: KEYSTREAM follows LOAD directly. This shortens latency for bring-up; it is not standard-compliant.

## Test plan
- Reset value check: assert reset with plaintext=64'hFEDCBA9876543210 -> z=0, ks_valid=0, ciphertext=64'hFEDCBA9876543210.
- Zero key: key=0 with the full run -> registers stay 0, z=0 on every cycle, ciphertext==plaintext for all plaintext values.
- Latency, macro undefined: key=64'h123456789ABCDEF0 -> ks_valid rises exactly 64 edges after reset release. With the macro defined it rises at 164 edges.
- Keystream match: key=64'h123456789ABCDEF0 with 128 KEYSTREAM cycles -> z sequence and ks match a bit-accurate software model of the rules above, every cycle. Likewise ciphertext == plaintext ^ ks with plaintext rotated left by 1 each cycle.
- Load injection: key=64'h1, macro undefined -> after load cycle 0, R1=1, R2=1, R3=1. Final register state matches the model.
- Reset mid-KEYSTREAM: after 20 keystream cycles assert reset -> ks=0 and ciphertext==plaintext immediately. Repeating the run gives a bit-identical keystream.
